cpu_mem_responder: RTL and testbench
====================================

Name: cpu_mem_responder

Overview:
- Memory-side responder for the single-cycle 8-bit CPU.
- Serves instruction fetches (pc -> ir) and data loads and stores (addr, wdata, mw -> rdata) with zero-latency reads and clocked writes.
- Contains a byte-serial program loader FSM. The loader writes 16-bit words into instruction memory and holds the CPU in reset while a load is in progress.
- Sits beside the CPU at top level; its cpu_reset output drives the CPU's reset input.

Parameters:
- IAW, 8, instruction memory address width; depth = 2^IAW words x 16 bits; pc uses its low IAW bits.
- DAW, 8, data memory address width; depth = 2^DAW bytes; addr uses its low DAW bits.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- pc  in  8  CPU program counter (fetch address)
- ir  out  16  instruction word at imem[pc]
- addr  in  8  CPU data address
- wdata  in  8  CPU store data
- mw  in  1  CPU memory-write strobe
- rdata  out  8  dmem[addr]
- ld_start  in  1  request a program load (level sampled in IDLE)
- ld_valid  in  1  ld_byte is valid
- ld_byte  in  8  load byte; high byte of each word first
- ld_last  in  1  qualifies the low byte as the final word
- ld_ready  out  1  loader accepts a byte this cycle
- ld_done  out  1  one-cycle pulse when load completes
- cpu_reset  out  1  reset to CPU

Behaviour:
- Reset and clock: reset synchronous, active-high; clock clk.
- Reads are combinational:
  - ir = imem[pc[IAW-1:0]]
  - rdata = dmem[addr[DAW-1:0]]
  - No read latency. Memory contents are not cleared by reset.
- Data write:
  - Condition: mw && state==IDLE && !reset.
  - Action: dmem[addr] <= wdata at the clock edge.
  - A read of the same address in the same cycle returns the old value; the new value is visible the next cycle.
- While state != IDLE, mw is ignored, because the CPU's MW is a decode of IR and is not qualified by reset.
- cpu_reset = reset | (state != IDLE). It is combinational.
- Reset values: state=IDLE, ld_addr=0, hi_reg=0, ld_done=0. Therefore ld_ready=0 and cpu_reset=1 while reset is high.
- FSM states:
  - IDLE:
    - ld_ready=0.
    - If ld_start: ld_addr<=0 -> LOAD_HI.
  - LOAD_HI:
    - ld_ready=1.
    - On ld_valid: hi_reg<=ld_byte -> LOAD_LO.
    - ld_last is ignored in this state.
  - LOAD_LO:
    - ld_ready=1.
    - On ld_valid: imem[ld_addr] <= {hi_reg, ld_byte}.
    - If ld_last or ld_addr == 2^IAW-1 -> RELEASE.
    - Otherwise ld_addr<=ld_addr+1 -> LOAD_HI.
  - RELEASE:
    - ld_ready=0, cpu_reset still 1.
    - ld_done<=1 registered, so it is high during the first IDLE cycle.
    - -> IDLE unconditionally.
- A handshake occurs only when ld_valid && ld_ready. No byte is consumed in IDLE or RELEASE.
- ld_valid low in LOAD_HI or LOAD_LO means the FSM holds its state; there is no timeout.
- Address overflow: the word at the top address ends the load even without ld_last; ld_addr does not wrap.
- Holding ld_start high at the return to IDLE starts a new load on the next cycle (ld_addr reset to 0).
- Reset asserted mid-load:
  - FSM returns to IDLE.
  - The partial hi_reg is discarded.
  - Words already written remain in imem.
  - No ld_done pulse.
- The CPU leaves reset on the first IDLE cycle with reset low, so its PC starts at 0 the next cycle.

Test Plan:
- Load three words 0x9842, 0x0210, 0xE000 (bytes 98,42,02,10,E0,00, ld_last with the 6th byte):
  - imem[0..2] hold the three words.
  - ld_done pulses exactly once, 7+ cycles after start.
  - cpu_reset is high from the cycle after ld_start through RELEASE.
  - ir at pc=1 reads 0x0210.
- Backpressure: deassert ld_valid for 5 cycles between the high and low bytes -> state held in LOAD_LO, no write, word assembled correctly afterward.
- Store then load: mw=1, addr=0x3C, wdata=0xA5 -> rdata=old value in the same cycle, 0xA5 the next cycle. addr=0x3C with mw=0 leaves the value unchanged.
- Store blocked: mw=1, addr=0x10, wdata=0x55 during LOAD_HI -> dmem[0x10] unchanged.
- Reset mid-load after the high byte of word 2 -> state IDLE, words 0..1 intact, ld_ready=0, no ld_done pulse, cpu_reset follows reset.
- Overflow with IAW=2: stream 4 words without ld_last -> RELEASE after word 3, ld_done pulses, a 9th byte is not accepted (ld_ready=0).

Source files
------------

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: instruction/data memory beside the single-cycle 8-bit CPU,
// plus a byte-serial program loader that holds the CPU in reset while it runs.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   pc   -> ir        combinational instruction fetch, imem[pc[IAW-1:0]]
//   addr -> rdata     combinational data read, dmem[addr[DAW-1:0]]
//   wdata, mw         clocked data store, honoured only in IDLE outside reset
//   ld_start          begin a program load (sampled in IDLE)
//   ld_valid/ld_ready byte handshake; ld_byte carries high byte then low byte
//   ld_last           marks the low byte of the final word
//   ld_done           one-cycle pulse on the first IDLE cycle after a load
//   cpu_reset         reset to the CPU: external reset or load in progress
module cpu_mem_responder #(
    parameter int unsigned IAW = 8,
    parameter int unsigned DAW = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  pc,
    output logic [15:0] ir,
    input  logic [7:0]  addr,
    input  logic [7:0]  wdata,
    input  logic        mw,
    output logic [7:0]  rdata,
    input  logic        ld_start,
    input  logic        ld_valid,
    input  logic [7:0]  ld_byte,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        ld_done,
    output logic        cpu_reset
);

    localparam int unsigned IDEPTH = 1 << IAW;
    localparam int unsigned DDEPTH = 1 << DAW;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_HI = 2'd1,
        LOAD_LO = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [IAW-1:0]   ld_addr, ld_addr_nxt;
    logic [7:0]       hi_reg, hi_nxt;
    logic             done_nxt;
    logic             imem_we;
    logic             handshake;
    logic             dmem_we;

    logic [15:0] imem [IDEPTH];
    logic [7:0]  dmem [DDEPTH];

    // Zero-latency reads; a same-cycle write is seen on the following cycle.
    assign ir    = imem[pc[IAW-1:0]];
    assign rdata = dmem[addr[DAW-1:0]];

    // Gating with reset keeps a byte from being consumed during a reset cycle.
    assign ld_ready  = !reset && (state == LOAD_HI || state == LOAD_LO);
    assign handshake = ld_valid && ld_ready;
    assign cpu_reset = reset || (state != IDLE);

    // CPU MW is an unqualified decode of IR, so stores are only trusted in IDLE.
    assign dmem_we = mw && (state == IDLE) && !reset;

    // Loader state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ld_addr <= '0;
            hi_reg  <= '0;
            ld_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            ld_addr <= ld_addr_nxt;
            hi_reg  <= hi_nxt;
            ld_done <= done_nxt;
        end
    end

    // Loader next-state and word assembly
    always_comb begin
        state_nxt   = state;
        ld_addr_nxt = ld_addr;
        hi_nxt      = hi_reg;
        done_nxt    = 1'b0;
        imem_we     = 1'b0;
        case (state)
            IDLE: begin
                if (ld_start) begin
                    ld_addr_nxt = '0;
                    state_nxt   = LOAD_HI;
                end
            end
            LOAD_HI: begin
                if (handshake) begin
                    hi_nxt    = ld_byte;
                    state_nxt = LOAD_LO;
                end
            end
            LOAD_LO: begin
                if (handshake) begin
                    imem_we = 1'b1;
                    // Top word ends the load: ld_addr never wraps.
                    if (ld_last || ld_addr == {IAW{1'b1}}) begin
                        state_nxt = RELEASE;
                    end else begin
                        ld_addr_nxt = ld_addr + IAW'(1);
                        state_nxt   = LOAD_HI;
                    end
                end
            end
            RELEASE: begin
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Instruction memory write port (loader only); contents survive reset
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[ld_addr] <= {hi_reg, ld_byte};
        end
    end

    // Data memory write port; contents survive reset
    always_ff @(posedge clk) begin
        if (dmem_we) begin
            dmem[addr[DAW-1:0]] <= wdata;
        end
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder: stimulus pushes expected output
// values into a queue, a negedge monitor pops and compares against the DUTs.
module tb_cpu_mem_responder;

    localparam int K_IR     = 0;
    localparam int K_RDATA  = 1;
    localparam int K_RDY    = 2;
    localparam int K_CRST   = 3;
    localparam int K_DONE   = 4;
    localparam int K_B_IR   = 5;
    localparam int K_B_RDY  = 6;
    localparam int K_B_DONE = 7;
    localparam int K_B_CRST = 8;

    typedef struct {
        int          kind;
        logic [15:0] val;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;

    logic [7:0]  pc, addr, wdata, ld_byte, rdata;
    logic [15:0] ir;
    logic        mw, ld_start, ld_valid, ld_last, ld_ready, ld_done, cpu_reset;

    logic [7:0]  b_pc, b_addr, b_wdata, b_ld_byte, b_rdata;
    logic [15:0] b_ir;
    logic        b_mw, b_ld_start, b_ld_valid, b_ld_last, b_ld_ready, b_ld_done, b_cpu_reset;

    exp_t        sbq[$];
    exp_t        e;
    logic [15:0] act;
    int          checks = 0;
    int          passed = 0;
    int          done_a = 0;
    int          done_b = 0;

    always #5 clk = ~clk;

    cpu_mem_responder #(.IAW(8), .DAW(8)) dut_a (
        .clk(clk), .reset(reset), .pc(pc), .ir(ir), .addr(addr), .wdata(wdata),
        .mw(mw), .rdata(rdata), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(ld_ready),
        .ld_done(ld_done), .cpu_reset(cpu_reset)
    );

    cpu_mem_responder #(.IAW(2), .DAW(8)) dut_b (
        .clk(clk), .reset(reset), .pc(b_pc), .ir(b_ir), .addr(b_addr), .wdata(b_wdata),
        .mw(b_mw), .rdata(b_rdata), .ld_start(b_ld_start), .ld_valid(b_ld_valid),
        .ld_byte(b_ld_byte), .ld_last(b_ld_last), .ld_ready(b_ld_ready),
        .ld_done(b_ld_done), .cpu_reset(b_cpu_reset)
    );

    task automatic chk(input string n, input logic [15:0] a, input logic [15:0] x);
        checks++;
        if (a === x) passed++;
        else $display("FAIL %s: got %h expected %h", n, a, x);
    endtask

    task automatic exp_push(input int k, input logic [15:0] v, input string n);
        exp_t t;
        t.kind = k;
        t.val  = v;
        t.name = n;
        sbq.push_back(t);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one loader byte and hold it until the handshake edge.
    task automatic send(input bit sel, input logic [7:0] b, input logic last);
        int n = 0;
        if (!sel) begin
            ld_valid = 1'b1; ld_byte = b; ld_last = last;
        end else begin
            b_ld_valid = 1'b1; b_ld_byte = b; b_ld_last = last;
        end
        while (!(sel ? b_ld_ready : ld_ready) && n < 50) begin
            tick();
            n++;
        end
        if (!(sel ? b_ld_ready : ld_ready)) chk("send_timeout", 16'(0), 16'(1));
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        b_ld_valid = 1'b0; b_ld_last = 1'b0;
    endtask

    // Monitor: compare every pending expectation against the live outputs.
    always @(negedge clk) begin
        if (ld_done === 1'b1) done_a++;
        if (b_ld_done === 1'b1) done_b++;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.kind)
                K_IR:     act = ir;
                K_RDATA:  act = 16'(rdata);
                K_RDY:    act = 16'(ld_ready);
                K_CRST:   act = 16'(cpu_reset);
                K_DONE:   act = 16'(ld_done);
                K_B_IR:   act = b_ir;
                K_B_RDY:  act = 16'(b_ld_ready);
                K_B_DONE: act = 16'(b_ld_done);
                K_B_CRST: act = 16'(b_cpu_reset);
                default:  act = 16'hxxxx;
            endcase
            chk(e.name, act, e.val);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        pc = '0; addr = '0; wdata = '0; mw = 1'b0;
        ld_start = 1'b0; ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0;
        b_pc = '0; b_addr = '0; b_wdata = '0; b_mw = 1'b0;
        b_ld_start = 1'b0; b_ld_valid = 1'b0; b_ld_byte = '0; b_ld_last = 1'b0;

        // Reset state
        repeat (2) tick();
        exp_push(K_RDY, 16'(0), "rst_ready");
        exp_push(K_CRST, 16'(1), "rst_cpu_reset");
        exp_push(K_DONE, 16'(0), "rst_done");
        exp_push(K_B_RDY, 16'(0), "rst_b_ready");
        tick();
        reset = 1'b0;
        exp_push(K_CRST, 16'(0), "idle_cpu_reset");

        // Stores: seed 0x10, then store-then-load on 0x3C
        mw = 1'b1; addr = 8'h10; wdata = 8'h33;
        tick();
        addr = 8'h3C; wdata = 8'h11;
        tick();
        wdata = 8'hA5;
        exp_push(K_RDATA, 16'h0011, "store_same_cycle_old");
        tick();
        mw = 1'b0; wdata = 8'hFF;
        exp_push(K_RDATA, 16'h00A5, "store_next_cycle_new");
        tick();
        exp_push(K_RDATA, 16'h00A5, "no_store_mw0");
        tick();

        // Three-word load
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        exp_push(K_CRST, 16'(1), "load_cpu_reset");
        exp_push(K_RDY, 16'(1), "load_ready");
        send(1'b0, 8'h98, 1'b0); send(1'b0, 8'h42, 1'b0);
        send(1'b0, 8'h02, 1'b0); send(1'b0, 8'h10, 1'b0);
        send(1'b0, 8'hE0, 1'b0); send(1'b0, 8'h00, 1'b1);
        exp_push(K_RDY, 16'(0), "release_ready");
        exp_push(K_CRST, 16'(1), "release_cpu_reset");
        exp_push(K_DONE, 16'(0), "release_done");
        tick();
        exp_push(K_DONE, 16'(1), "done_pulse");
        exp_push(K_CRST, 16'(0), "done_cpu_reset");
        tick();
        exp_push(K_DONE, 16'(0), "done_single");
        pc = 8'd0; exp_push(K_IR, 16'h9842, "ir0"); tick();
        pc = 8'd1; exp_push(K_IR, 16'h0210, "ir1"); tick();
        pc = 8'd2; exp_push(K_IR, 16'hE000, "ir2"); tick();

        // Backpressure between high and low byte
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        pc = 8'd0;
        send(1'b0, 8'h12, 1'b0);
        for (int i = 0; i < 5; i++) begin
            exp_push(K_RDY, 16'(1), "stall_ready");
            exp_push(K_IR, 16'h9842, "stall_no_write");
            tick();
        end
        send(1'b0, 8'h34, 1'b1);
        tick();
        exp_push(K_IR, 16'h1234, "stall_word");
        tick();

        // Blocked store during load, then reset mid-load
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        mw = 1'b1; addr = 8'h10; wdata = 8'h55;
        exp_push(K_CRST, 16'(1), "blocked_cpu_reset");
        tick();
        mw = 1'b0;
        exp_push(K_RDATA, 16'h0033, "store_blocked");
        send(1'b0, 8'hAA, 1'b0); send(1'b0, 8'hBB, 1'b0);
        send(1'b0, 8'hCC, 1'b0); send(1'b0, 8'hDD, 1'b0);
        send(1'b0, 8'hEE, 1'b0);
        reset = 1'b1;
        exp_push(K_RDY, 16'(0), "midrst_ready_hi");
        exp_push(K_CRST, 16'(1), "midrst_cpu_reset_hi");
        tick();
        reset = 1'b0;
        exp_push(K_RDY, 16'(0), "midrst_ready_idle");
        exp_push(K_CRST, 16'(0), "midrst_cpu_reset_lo");
        exp_push(K_DONE, 16'(0), "midrst_no_done");
        tick();
        exp_push(K_DONE, 16'(0), "midrst_no_done2");
        pc = 8'd0; exp_push(K_IR, 16'hAABB, "midrst_ir0"); tick();
        pc = 8'd1; exp_push(K_IR, 16'hCCDD, "midrst_ir1"); tick();
        pc = 8'd2; exp_push(K_IR, 16'hE000, "midrst_ir2_untouched"); tick();

        // Overflow on the IAW=2 instance
        b_ld_start = 1'b1;
        tick();
        b_ld_start = 1'b0;
        for (int w = 0; w < 4; w++) begin
            send(1'b1, 8'(2 * w + 1), 1'b0);
            send(1'b1, 8'(2 * w + 2), 1'b0);
        end
        exp_push(K_B_RDY, 16'(0), "ovf_release_ready");
        exp_push(K_B_CRST, 16'(1), "ovf_release_cpu_reset");
        b_ld_valid = 1'b1; b_ld_byte = 8'h09;
        tick();
        exp_push(K_B_RDY, 16'(0), "ovf_9th_not_ready");
        exp_push(K_B_DONE, 16'(1), "ovf_done");
        exp_push(K_B_CRST, 16'(0), "ovf_cpu_reset_lo");
        tick();
        b_ld_valid = 1'b0;
        exp_push(K_B_DONE, 16'(0), "ovf_done_single");
        exp_push(K_B_RDY, 16'(0), "ovf_stays_idle");
        b_pc = 8'd0; exp_push(K_B_IR, 16'h0102, "ovf_ir0"); tick();
        b_pc = 8'd3; exp_push(K_B_IR, 16'h0708, "ovf_ir3"); tick();
        b_pc = 8'd5; exp_push(K_B_IR, 16'h0304, "ovf_pc_low_bits"); tick();

        repeat (2) tick();
        chk("done_count_a", 16'(done_a), 16'(2));
        chk("done_count_b", 16'(done_b), 16'(1));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
